adma_chn_arbiter: RTL and testbench

- Weighted round-robin scheduler that shares the single AXI4 read/write burst datapath between the DMA channels.
- Channels are enabled and weighted by the CSR outputs dma_en, chn_ctrl_en and chn_arb_rate.
- One channel at a time is granted a budget of (chn_arb_rate+1) bursts. The arbiter then waits for that channel's outstanding bursts to drain before rotating to the next eligible channel.

---
 rtl/adma_pkg.sv | 16 +
 rtl/adma_rr_picker.sv | 31 +++
 rtl/adma_chn_arbiter.sv | 142 ++++++++++++++
 tb/tb_adma_chn_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adma_pkg.sv
// Shared types and helpers for the ADMA channel arbitration logic.
// Imported by the channel arbiter and its round-robin picker.
package adma_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } adma_arb_state_e;

    // Credit/outstanding counters need one extra bit so a weight of 2^W-1 yields 2^W bursts.
    function automatic int unsigned crd_width(input int unsigned arb_w);
        return arb_w + 1;
    endfunction

endpackage

// File: rtl/adma_rr_picker.sv
// Combinational rotate-priority picker: first set bit of elig at or above rr_ptr, wrapping.
// Kept generic so other channel-arbitration points can reuse it.
module adma_rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    elig,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [ID_W-1:0] pick,
    output logic            pick_vld
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % N);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign pick_vld = |elig;

endmodule

// File: rtl/adma_chn_arbiter.sv
// Weighted round-robin scheduler sharing the AXI burst datapath between DMA channels.
// A granted channel spends up to rate+1 bursts, then its outstanding bursts drain before rotation.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ARB_IDLE  | no grant; pick next eligible channel from rr_ptr upward
//   ARB_GRANT | channel gnt_id may start bursts while credit remains
//   ARB_DRAIN | grant withdrawn; wait for outstanding bursts to complete
module adma_chn_arbiter
    import adma_pkg::*;
#(
    parameter  int DMA_CHN_NUM   = 4,
    parameter  int DMA_CHN_ARB_W = 3,
    localparam int CHN_ID_W      = $clog2(DMA_CHN_NUM),
    localparam int CRD_W         = int'(crd_width(DMA_CHN_ARB_W))
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   dma_en_i,
    input  logic [DMA_CHN_NUM-1:0]                 chn_ctrl_en_i,
    input  logic [DMA_CHN_NUM*DMA_CHN_ARB_W-1:0]   chn_arb_rate_i,
    input  logic [DMA_CHN_NUM-1:0]                 chn_req_i,
    input  logic                                   burst_start_i,
    input  logic                                   burst_done_i,
    output logic                                   gnt_vld_o,
    output logic [DMA_CHN_NUM-1:0]                 gnt_oh_o,
    output logic [CHN_ID_W-1:0]                    gnt_id_o,
    output logic [CRD_W-1:0]                       gnt_credit_o,
    output logic                                   arb_busy_o
);

    localparam logic [CRD_W-1:0] CRD_ONE = CRD_W'(1);
    localparam logic [CRD_W-1:0] CRD_MAX = {CRD_W{1'b1}};

    adma_arb_state_e            state, state_nxt;
    logic [CHN_ID_W-1:0]        rr_ptr, rr_ptr_nxt;
    logic [CHN_ID_W-1:0]        gnt_id, gnt_id_nxt;
    logic [CRD_W-1:0]           credit, credit_nxt;
    logic [CRD_W-1:0]           outst, outst_nxt;

    logic [DMA_CHN_NUM-1:0]     elig;
    logic [CHN_ID_W-1:0]        pick;
    logic                       pick_vld;
    logic [DMA_CHN_ARB_W-1:0]   pick_rate;
    logic                       grant_release;
    logic [CHN_ID_W-1:0]        rr_after_gnt;

    assign elig = chn_req_i & chn_ctrl_en_i & {DMA_CHN_NUM{dma_en_i}};

    adma_rr_picker #(
        .N    (DMA_CHN_NUM),
        .ID_W (CHN_ID_W)
    ) u_picker (
        .elig     (elig),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    always_comb begin
        pick_rate = '0;
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            if (pick == CHN_ID_W'(c)) begin
                pick_rate = chn_arb_rate_i[c*DMA_CHN_ARB_W +: DMA_CHN_ARB_W];
            end
        end
    end

    assign grant_release = (burst_start_i && (credit == CRD_ONE)) ||
                           !chn_req_i[gnt_id] ||
                           !chn_ctrl_en_i[gnt_id] ||
                           !dma_en_i;

    assign rr_after_gnt = (gnt_id == CHN_ID_W'(DMA_CHN_NUM - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        gnt_id_nxt = gnt_id;
        credit_nxt = credit;
        outst_nxt  = outst;
        case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_id_nxt = pick;
                    credit_nxt = CRD_W'(pick_rate) + CRD_ONE;
                    state_nxt  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (burst_start_i && (credit != '0)) begin
                    credit_nxt = credit - CRD_ONE;
                end
                if (burst_start_i && !burst_done_i && (outst != CRD_MAX)) begin
                    outst_nxt = outst + CRD_ONE;
                end else if (!burst_start_i && burst_done_i && (outst != '0)) begin
                    outst_nxt = outst - CRD_ONE;
                end
                if (grant_release) begin
                    state_nxt = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                // A start here is a datapath protocol violation and is deliberately not counted.
                if (burst_done_i && (outst != '0)) begin
                    outst_nxt = outst - CRD_ONE;
                end
                if ((outst == '0) || ((outst == CRD_ONE) && burst_done_i)) begin
                    rr_ptr_nxt = rr_after_gnt;
                    credit_nxt = '0;
                    state_nxt  = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            gnt_id <= '0;
            credit <= '0;
            outst  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            gnt_id <= gnt_id_nxt;
            credit <= credit_nxt;
            outst  <= outst_nxt;
        end
    end

    assign gnt_vld_o    = (state == ARB_GRANT);
    assign gnt_oh_o     = gnt_vld_o ? (DMA_CHN_NUM'(1) << gnt_id) : '0;
    assign gnt_id_o     = gnt_id;
    assign gnt_credit_o = credit;
    assign arb_busy_o   = (state != ARB_IDLE);

endmodule

// File: tb/tb_adma_chn_arbiter.sv
// Directed bench for adma_chn_arbiter: grant expectations go through a scoreboard queue
// checked by a monitor process; cycle-level counter/state checks are done inline.
module tb_adma_chn_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        dma_en_i;
    logic [3:0]  chn_ctrl_en_i;
    logic [11:0] chn_arb_rate_i;
    logic [3:0]  chn_req_i;
    logic        burst_start_i;
    logic        burst_done_i;
    logic        gnt_vld_o;
    logic [3:0]  gnt_oh_o;
    logic [1:0]  gnt_id_o;
    logic [3:0]  gnt_credit_o;
    logic        arb_busy_o;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] oh;
        logic [3:0] credit;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    adma_chn_arbiter #(
        .DMA_CHN_NUM   (4),
        .DMA_CHN_ARB_W (3)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .dma_en_i       (dma_en_i),
        .chn_ctrl_en_i  (chn_ctrl_en_i),
        .chn_arb_rate_i (chn_arb_rate_i),
        .chn_req_i      (chn_req_i),
        .burst_start_i  (burst_start_i),
        .burst_done_i   (burst_done_i),
        .gnt_vld_o      (gnt_vld_o),
        .gnt_oh_o       (gnt_oh_o),
        .gnt_id_o       (gnt_id_o),
        .gnt_credit_o   (gnt_credit_o),
        .arb_busy_o     (arb_busy_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_grant(input int id, input int cr);
        exp_t e;
        e.id     = 2'(id);
        e.oh     = 4'(1 << id);
        e.credit = 4'(cr);
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev = 1'b0;
            end else begin
                if (gnt_vld_o && !prev) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_grant: got grant to ch %0d, required no grant", gnt_id_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_id", 32'(gnt_id_o), 32'(e.id));
                        chk("grant_oh", 32'(gnt_oh_o), 32'(e.oh));
                        chk("grant_credit", 32'(gnt_credit_o), 32'(e.credit));
                    end
                end
                prev = gnt_vld_o;
            end
        end
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (!gnt_vld_o && n < 20) begin
            tick();
            n++;
        end
        chk("grant_wait", 32'(gnt_vld_o), 32'd1);
    endtask

    // start+done in the same cycle, n times back to back; credit tracked from c
    task automatic burst_pairs(input int n, input int c);
        for (int b = 0; b < n; b++) begin
            burst_start_i = 1'b1;
            burst_done_i  = 1'b1;
            tick();
            chk("pair_credit", 32'(gnt_credit_o), 32'(c - 1 - b));
        end
        burst_start_i = 1'b0;
        burst_done_i  = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, required end before 200000");
        $fatal(1);
    end

    initial begin
        aresetn        = 1'b0;
        dma_en_i       = 1'b0;
        chn_ctrl_en_i  = 4'h0;
        chn_arb_rate_i = 12'h000;
        chn_req_i      = 4'h0;
        burst_start_i  = 1'b0;
        burst_done_i   = 1'b0;

        fork
            monitor();
        join_none

        // reset state
        tick();
        tick();
        chk("rst_vld", 32'(gnt_vld_o), 32'd0);
        chk("rst_oh", 32'(gnt_oh_o), 32'd0);
        chk("rst_id", 32'(gnt_id_o), 32'd0);
        chk("rst_credit", 32'(gnt_credit_o), 32'd0);
        chk("rst_busy", 32'(arb_busy_o), 32'd0);
        aresetn = 1'b1;

        // ch1 only, rate 2: 3 bursts, credit 3->2->1->0
        dma_en_i       = 1'b1;
        chn_ctrl_en_i  = 4'hF;
        chn_arb_rate_i = 12'h010;
        chn_req_i      = 4'b0010;
        chk("s1_pre_grant", 32'(gnt_vld_o), 32'd0);
        expect_grant(1, 3);
        tick();
        chk("s1_latency", 32'(gnt_vld_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            burst_start_i = 1'b1;
            tick();
            burst_start_i = 1'b0;
            chk("s1_credit", 32'(gnt_credit_o), 32'(2 - k));
            chk("s1_vld_after_start", 32'(gnt_vld_o), (k < 2) ? 32'd1 : 32'd0);
            if (k == 2) begin
                chk("s1_drain_id", 32'(gnt_id_o), 32'd1);
                chn_req_i = 4'b0000;
            end
            burst_done_i = 1'b1;
            tick();
            burst_done_i = 1'b0;
        end
        chk("s1_idle", 32'(arb_busy_o), 32'd0);
        chk("s1_idle_credit", 32'(gnt_credit_o), 32'd0);

        // all four, rate 0: grants 0,1,2,3,0
        do_reset();
        chn_arb_rate_i = 12'h000;
        chn_req_i      = 4'hF;
        expect_grant(0, 1);
        expect_grant(1, 1);
        expect_grant(2, 1);
        expect_grant(3, 1);
        expect_grant(0, 1);
        for (int g = 0; g < 5; g++) begin
            wait_grant();
            burst_pairs(1, 1);
            chk("s2_vld_drop", 32'(gnt_vld_o), 32'd0);
            if (g == 4) chn_req_i = 4'h0;
        end
        tick();
        tick();

        // ch0 rate 3 and ch2 rate 0: ch0 x4, ch2 x1, ch0 x4
        do_reset();
        chn_arb_rate_i = 12'h003;
        chn_req_i      = 4'b0101;
        expect_grant(0, 4);
        expect_grant(2, 1);
        expect_grant(0, 4);
        wait_grant();
        burst_pairs(4, 4);
        wait_grant();
        burst_pairs(1, 1);
        wait_grant();
        burst_pairs(4, 4);
        chn_req_i = 4'h0;
        tick();
        tick();
        chk("s3_idle", 32'(arb_busy_o), 32'd0);

        // ch0 rate 7, request drops with 2 bursts outstanding
        do_reset();
        chn_arb_rate_i = 12'h007;
        chn_req_i      = 4'b0001;
        expect_grant(0, 8);
        wait_grant();
        burst_start_i = 1'b1;
        tick();
        tick();
        burst_start_i = 1'b0;
        chn_req_i     = 4'b0000;
        chk("s4_credit", 32'(gnt_credit_o), 32'd6);
        tick();
        chk("s4_drain_vld", 32'(gnt_vld_o), 32'd0);
        chk("s4_drain_busy", 32'(arb_busy_o), 32'd1);
        chk("s4_drain_id", 32'(gnt_id_o), 32'd0);
        burst_start_i = 1'b1;
        tick();
        burst_start_i = 1'b0;
        chk("s4_drain_start_ignored", 32'(gnt_credit_o), 32'd6);
        chk("s4_drain_hold", 32'(arb_busy_o), 32'd1);
        burst_done_i = 1'b1;
        tick();
        chk("s4_one_done", 32'(arb_busy_o), 32'd1);
        tick();
        burst_done_i = 1'b0;
        chk("s4_two_done", 32'(arb_busy_o), 32'd0);
        chk("s4_idle_credit", 32'(gnt_credit_o), 32'd0);
        chn_arb_rate_i = 12'h000;
        chn_req_i      = 4'hF;
        expect_grant(1, 1);
        wait_grant();
        burst_pairs(1, 1);
        chn_req_i = 4'h0;
        tick();
        tick();

        // simultaneous start+done with one outstanding
        do_reset();
        chn_arb_rate_i = 12'hE00;
        chn_req_i      = 4'b1000;
        expect_grant(3, 8);
        wait_grant();
        burst_start_i = 1'b1;
        tick();
        burst_done_i = 1'b1;
        tick();
        burst_start_i = 1'b0;
        burst_done_i  = 1'b0;
        chn_req_i     = 4'b0000;
        chk("s5_credit", 32'(gnt_credit_o), 32'd6);
        tick();
        tick();
        chk("s5_outst_kept", 32'(arb_busy_o), 32'd1);
        burst_done_i = 1'b1;
        tick();
        burst_done_i = 1'b0;
        chk("s5_outst_one", 32'(arb_busy_o), 32'd0);

        // global disable blocks grants
        chn_arb_rate_i = 12'h000;
        dma_en_i       = 1'b0;
        chn_req_i      = 4'hF;
        repeat (5) tick();
        chk("s6_dis_vld", 32'(gnt_vld_o), 32'd0);
        chk("s6_dis_busy", 32'(arb_busy_o), 32'd0);
        chn_req_i = 4'h0;
        dma_en_i  = 1'b1;

        // move rr_ptr off zero, then reset mid-grant with 3 outstanding
        chn_req_i = 4'b0010;
        expect_grant(1, 1);
        wait_grant();
        burst_pairs(1, 1);
        chn_req_i = 4'b0000;
        tick();
        tick();
        chn_arb_rate_i = 12'h1C0;
        chn_req_i      = 4'b0100;
        expect_grant(2, 8);
        wait_grant();
        burst_start_i = 1'b1;
        repeat (3) tick();
        burst_start_i = 1'b0;
        chk("s6_pre_rst_credit", 32'(gnt_credit_o), 32'd5);
        aresetn = 1'b0;
        #1;
        chk("s6_rst_vld", 32'(gnt_vld_o), 32'd0);
        chk("s6_rst_oh", 32'(gnt_oh_o), 32'd0);
        chk("s6_rst_id", 32'(gnt_id_o), 32'd0);
        chk("s6_rst_credit", 32'(gnt_credit_o), 32'd0);
        chk("s6_rst_busy", 32'(arb_busy_o), 32'd0);
        tick();
        aresetn   = 1'b1;
        chn_req_i = 4'b0101;
        chk("s6_post_rst_busy", 32'(arb_busy_o), 32'd0);
        expect_grant(0, 1);
        wait_grant();
        burst_start_i = 1'b1;
        tick();
        burst_start_i = 1'b0;
        chn_req_i     = 4'b0000;
        chk("s6_drain", 32'(arb_busy_o), 32'd1);
        burst_done_i = 1'b1;
        tick();
        burst_done_i = 1'b0;
        chk("s6_outst_cleared", 32'(arb_busy_o), 32'd0);

        repeat (4) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
